// File: rtl/fec_pipeline_controller.sv
// FEC pipeline controller: sequences one frame of symbols from an input
// buffer through a chain of fixed-latency stages into an output buffer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  global enable, low freezes the controller
//   req / ack           four-phase frame handshake
//   buff_empty          input buffer empty (inserts bubbles)
//   buff_full           output buffer full (freezes the pipeline)
//   stage_bypass        per-stage bypass mask, captured at frame start
//   rd_en_buff          pop one symbol from the input buffer
//   wr_en_buff          push one symbol to the output buffer
//   stage_en            per-stage advance enable, bit 0 = first stage
//   busy                high whenever a frame is in progress
//   frame_cnt           completed frames, wrapping
module fec_pipeline_controller #(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_LAT  = 2,
    parameter int FRAME_LEN  = 64,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  req,
    input  logic                  buff_empty,
    input  logic                  buff_full,
    input  logic [NUM_STAGES-1:0] stage_bypass,
    output logic                  ack,
    output logic                  rd_en_buff,
    output logic                  wr_en_buff,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  busy,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam int PIPE_LAT = NUM_STAGES * STAGE_LAT;
    localparam int LEN_W    = $clog2(FRAME_LEN + 1);

    localparam logic [LEN_W-1:0] LEN  = LEN_W'(FRAME_LEN);
    localparam logic [LEN_W-1:0] LAST = LEN_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    logic [LEN_W-1:0]      rd_cnt;
    logic [LEN_W-1:0]      wr_cnt;
    logic [PIPE_LAT-1:0]   vld;
    logic [NUM_STAGES-1:0] byp;
    logic                  stall;
    logic                  active;
    logic                  advance;
    logic                  last_rd;
    logic                  last_wr;

    // A full output buffer and a disabled controller both freeze
    // every stage; an empty input buffer only withholds the read.
    assign stall   = buff_full | ~en;
    assign active  = (state == RUN) || (state == DRAIN);
    assign advance = active && !stall;

    assign rd_en_buff = (state == RUN) && !stall && !buff_empty
                        && (rd_cnt < LEN);

    // The valid line tracks which pipeline slots carry a real symbol,
    // so its tail tells us when a symbol reaches the output.
    assign wr_en_buff = vld[PIPE_LAT-1] && advance;

    // Bypassed stages stay idle but the symbol path length is fixed.
    assign stage_en = {NUM_STAGES{advance}} & ~byp;

    assign last_rd = rd_en_buff && (rd_cnt == LAST);
    assign last_wr = wr_en_buff && (wr_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            vld       <= '0;
            byp       <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (advance) begin
                vld <= (vld << 1) | PIPE_LAT'(rd_en_buff);
            end
            if (rd_en_buff) begin
                rd_cnt <= rd_cnt + LEN_W'(1);
            end
            if (wr_en_buff) begin
                wr_cnt <= wr_cnt + LEN_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (en && req) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        byp    <= stage_bypass;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                        vld    <= '0;
                    end
                end
                RUN: begin
                    if (last_rd) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_wr) begin
                        state     <= DONE;
                        ack       <= 1'b1;
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (en && !req) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fec_pipeline_controller.sv
// Directed bench for fec_pipeline_controller with
// NUM_STAGES=4, STAGE_LAT=2, FRAME_LEN=8 (PIPE_LAT=8).
module tb_fec_pipeline_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       req;
    logic       buff_empty;
    logic       buff_full;
    logic [3:0] stage_bypass;
    logic       ack;
    logic       rd_en_buff;
    logic       wr_en_buff;
    logic [3:0] stage_en;
    logic       busy;
    logic [7:0] frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    fec_pipeline_controller #(
        .NUM_STAGES(4),
        .STAGE_LAT (2),
        .FRAME_LEN (8),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .buff_empty  (buff_empty),
        .buff_full   (buff_full),
        .stage_bypass(stage_bypass),
        .ack         (ack),
        .rd_en_buff  (rd_en_buff),
        .wr_en_buff  (wr_en_buff),
        .stage_en    (stage_en),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {ack, busy, rd_en_buff, wr_en_buff, stage_en};
    endfunction

    // Runs one frame cycle by cycle. Cycle 0 is the cycle in which req
    // is first sampled; masks give the expected cycles of each output.
    task automatic run_frame(input string name,
                             input logic [31:0] rd_m,
                             input logic [31:0] wr_m,
                             input logic [31:0] act_m,
                             input logic [3:0] byp0,
                             input logic [3:0] byp1,
                             input int done_c,
                             input int e_lo, input int e_hi,
                             input int f_lo, input int f_hi,
                             input logic [7:0] exp_cnt);
        logic [7:0] exp;
        for (int c = 0; c <= done_c + 3; c++) begin
            @(negedge clk);
            req          = (c <= done_c + 1);
            buff_empty   = (c >= e_lo) && (c <= e_hi);
            buff_full    = (c >= f_lo) && (c <= f_hi);
            stage_bypass = (c >= 4) ? byp1 : byp0;
            #1;
            exp = {(c >= done_c) && (c <= done_c + 2),
                   (c >= 1) && (c <= done_c + 2),
                   rd_m[c], wr_m[c],
                   act_m[c] ? ~byp0 : 4'h0};
            check_eq($sformatf("%s c%0d", name, c),
                     {24'h0, outs()}, {24'h0, exp});
        end
        check_eq({name, " frame_cnt"}, {24'h0, frame_cnt},
                 {24'h0, exp_cnt});
    endtask

    task automatic quick_frame();
        int k;
        @(negedge clk);
        req        = 1'b1;
        buff_empty = 1'b0;
        buff_full  = 1'b0;
        k = 0;
        while (!ack && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("quick ack", {31'h0, ack}, 32'h1);
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        req          = 1'b0;
        buff_empty   = 1'b0;
        buff_full    = 1'b0;
        stage_bypass = 4'h0;

        // Reset with random other inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {en, req, buff_empty, buff_full} = 4'($urandom);
            stage_bypass = 4'($urandom);
            #1;
            if (i >= 1) begin
                check_eq($sformatf("rst outs %0d", i),
                         {24'h0, outs()}, 32'h0);
                check_eq($sformatf("rst cnt %0d", i),
                         {24'h0, frame_cnt}, 32'h0);
            end
        end
        @(negedge clk);
        rst          = 1'b0;
        en           = 1'b1;
        req          = 1'b0;
        buff_empty   = 1'b0;
        buff_full    = 1'b0;
        stage_bypass = 4'h0;

        // Abort a frame with reset at cycle 5.
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            req = (c <= 5);
            rst = (c == 5);
            #1;
            if (c == 2) begin
                check_eq("abort rd c2", {31'h0, rd_en_buff}, 32'h1);
            end
            if (c >= 6) begin
                check_eq($sformatf("abort c%0d", c),
                         {24'h0, outs()}, 32'h0);
            end
        end
        check_eq("abort frame_cnt", {24'h0, frame_cnt}, 32'h0);

        run_frame("base", 32'h1FE, 32'h1FE00, 32'h1FFFE,
                  4'h0, 4'h0, 17, 99, 0, 99, 0, 8'd1);
        run_frame("empty", 32'h0FC6, 32'hFC600, 32'hFFFFE,
                  4'h0, 4'h0, 20, 3, 5, 99, 0, 8'd2);
        run_frame("full", 32'h1FE, 32'h7F200, 32'h7F3FE,
                  4'h0, 4'h0, 19, 99, 0, 10, 11, 8'd3);
        run_frame("bypass", 32'h1FE, 32'h1FE00, 32'h1FFFE,
                  4'b0100, 4'hF, 17, 99, 0, 99, 0, 8'd4);

        for (int f = 0; f < 251; f++) begin
            quick_frame();
        end
        check_eq("cnt 255", {24'h0, frame_cnt}, 32'd255);
        quick_frame();
        check_eq("cnt wrap", {24'h0, frame_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fec_pipeline_controller.md
FEC_PIPELINE_CONTROLLER -- requirements
Module: fec_pipeline_controller

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of chained processing stages (encoder, modulator, demodulator, decoder), range 1..8.
REQ-002 Parameter STAGE_LAT, default 2: cycles each stage adds to the symbol path, range 1..16.
REQ-003 Parameter FRAME_LEN, default 64: symbols per frame, range 1..4096.
REQ-004 Parameter CNT_W, default 8: width of the completed-frame counter.
REQ-005 Derived PIPE_LAT = NUM_STAGES*STAGE_LAT.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 en  in  1  global enable; low freezes the controller.
REQ-009 req  in  1  frame request, four-phase with ack.
REQ-010 buff_empty  in  1  input symbol buffer empty.
REQ-011 buff_full  in  1  output symbol buffer full.
REQ-012 stage_bypass  in  NUM_STAGES  per-stage bypass mask, captured at frame start.
REQ-013 ack  out  1  frame complete, held until req drops.
REQ-014 rd_en_buff  out  1  pop one symbol from the input buffer this cycle.
REQ-015 wr_en_buff  out  1  push one symbol to the output buffer this cycle.
REQ-016 stage_en  out  NUM_STAGES  per-stage advance enable; bit 0 is the first stage.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE->RUN when en=1 and req=1; on that transition, stage_bypass is captured, and the read counter, write counter and valid delay line are cleared.
REQ-021 Define stall = buff_full OR NOT en; stall is evaluated combinationally in the same cycle.
REQ-022 rd_en_buff = (state RUN) AND NOT stall AND NOT buff_empty AND (rd_cnt < FRAME_LEN), combinational.
REQ-023 Delay line of PIPE_LAT valid bits: it shifts once per non-stalled cycle in RUN or DRAIN, and its input bit is rd_en_buff.
REQ-024 wr_en_buff = tail valid bit AND NOT stall AND (state RUN or DRAIN).
REQ-025 stage_en[i] = (state RUN or DRAIN) AND NOT stall AND NOT captured bypass[i]; a bypassed stage does not change PIPE_LAT.
REQ-026 rd_cnt increments on each rd_en_buff; wr_cnt increments on each wr_en_buff; both counters are wide enough to hold FRAME_LEN.
REQ-027 RUN->DRAIN on the cycle the FRAME_LEN-th read occurs.
REQ-028 DRAIN->DONE on the cycle the FRAME_LEN-th write occurs; frame_cnt increments on that same edge.
REQ-029 DONE: ack=1; when req=0, the next state is IDLE and ack falls.
REQ-030 buff_empty during RUN inserts a bubble; the pipeline keeps advancing and no read occurs.
REQ-031 buff_full freezes the whole pipeline: no read, no write, all stage_en low; no symbol is lost or duplicated.
REQ-032 req is ignored outside IDLE.
REQ-033 With no stalls or bubbles: first read at cycle t+1 after req is sampled at t, first write at t+1+PIPE_LAT, DONE entered at t+1+FRAME_LEN+PIPE_LAT.
REQ-034 buff_empty and buff_full asserted simultaneously: buff_full governs and the pipeline freezes.

Reset
REQ-035 rst=1 forces IDLE, clears all counters, the delay line and captured bypass, and drives ack, rd_en_buff, wr_en_buff, stage_en, busy to 0 and frame_cnt to 0 by the next edge.
REQ-036 rst in any state aborts the frame with no further reads or writes; rst has priority over all other inputs.

Verification
(All scenarios use NUM_STAGES=4, STAGE_LAT=2, FRAME_LEN=8, so PIPE_LAT=8.)
REQ-037 rst high 2 cycles, other inputs random -> all outputs 0, frame_cnt=0.
REQ-038 req at cycle 0, buffers never empty/full, bypass=0 -> rd_en cycles 1-8, wr_en cycles 9-16, stage_en=4'hF cycles 1-16, ack from cycle 17 until req drops, frame_cnt=1.
REQ-039 As REQ-038 with buff_empty high cycles 3-5 -> exactly 8 reads, none in cycles 3-5, 8 writes, ack at cycle 20.
REQ-040 As REQ-038 with buff_full high cycles 10-11 -> rd_en, wr_en and stage_en all 0 in cycles 10-11, 8 writes total, ack at cycle 19.
REQ-041 bypass=4'b0100 at start -> stage_en[2]=0 throughout the frame, other bits as REQ-038, same latency; bypass changed mid-frame has no effect.
REQ-042 rst at cycle 5 of a frame -> IDLE at cycle 6, no reads or writes afterwards, frame_cnt=0; 2^CNT_W back-to-back frames -> frame_cnt wraps to 0.
